// File: rtl/d_cache_pkg.sv
// d_cache_pkg: shared widths, FSM state encoding and word/line helpers for d_cache.
// Ports: none (package).
// Used by d_cache and d_cache_array via import d_cache_pkg::*.
package d_cache_pkg;

  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int MEM_AW = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_WRITEBACK,
    ST_REFILL,
    ST_RESPOND
  } state_t;

  // Word 0 is line bits [31:0].
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [1:0] sel);
    return line[int'(sel)*WORD_W +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] word_merge(input logic [LINE_W-1:0] line,
                                                   input logic [1:0] sel,
                                                   input logic [WORD_W-1:0] word);
    logic [LINE_W-1:0] r;
    r = line;
    r[int'(sel)*WORD_W +: WORD_W] = word;
    return r;
  endfunction

endpackage

// File: rtl/d_cache_array.sv
// d_cache_array: tag/valid/dirty/data storage of the direct-mapped cache.
// Ports: clk/rst; idx selects the line for both the asynchronous read (rd_*) and the
// synchronous write (line_we = full refill write, word_we = word merge + dirty set).
module d_cache_array
  import d_cache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int TAG_W = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(LINES)-1:0]     idx,
  output logic                         rd_valid,
  output logic                         rd_dirty,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [LINE_W-1:0]            rd_line,
  input  logic                         line_we,
  input  logic [TAG_W-1:0]             line_tag,
  input  logic [LINE_W-1:0]            line_dat,
  input  logic                         word_we,
  input  logic [1:0]                   word_sel_in,
  input  logic [WORD_W-1:0]            word_dat
);

  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tags [LINES];
  logic [LINE_W-1:0] data [LINES];

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tags[idx];
  assign rd_line  = data[idx];

  // Only the status bits need reset; tag/data contents are qualified by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (word_we) begin
      dirty[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tags[idx] <= line_tag;
      data[idx] <= line_dat;
    end else if (word_we) begin
      data[idx] <= word_merge(data[idx], word_sel_in, word_dat);
    end
  end

endmodule

// File: rtl/d_cache.sv
// d_cache: direct-mapped write-back write-allocate cache, 32-bit core port, 128-bit line memory.
// Ports: CLK/RST; REQ_* single-outstanding request, RESP_* one-cycle response pulse;
// MEM_* active-low CSN/WEN line port. Macro D_CACHE_STATS_EN adds HIT_CNT/MISS_CNT outputs.
module d_cache
  import d_cache_pkg::*;
#(
  parameter int LINES       = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic                REQ_WEN,
  input  logic [13:0]         REQ_ADDR,
  input  logic [WORD_W-1:0]   REQ_WDATA,
  output logic                RESP_VALID,
  output logic [WORD_W-1:0]   RESP_RDATA,
  output logic                MEM_CSN,
  output logic                MEM_WEN,
  output logic [MEM_AW-1:0]   MEM_ADDR,
  output logic [LINE_W-1:0]   MEM_DOUT,
  input  logic [LINE_W-1:0]   MEM_DI
`ifdef D_CACHE_STATS_EN
  ,
  output logic [31:0]         HIT_CNT,
  output logic [31:0]         MISS_CNT
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = MEM_AW - IDX_W;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  // Writeback occupies MEM_LATENCY cycles; refill one more so MEM_DI is sampled
  // MEM_LATENCY cycles after its CSN pulse.
  localparam logic [CNT_W-1:0] WB_LAST = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] RF_LAST = CNT_W'(MEM_LATENCY);

  state_t              state, state_n;
  logic [MEM_AW-1:0]   req_line;
  logic [1:0]          req_word;
  logic                req_wen;
  logic [WORD_W-1:0]   req_wdata;
  logic [CNT_W-1:0]    cnt;
  logic [WORD_W-1:0]   rdata_q;

  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                rd_valid, rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic                hit, accept, line_we, word_we, mem_go;
  logic                unused_addr;

  assign req_idx     = req_line[IDX_W-1:0];
  assign req_tag     = req_line[MEM_AW-1:IDX_W];
  assign hit         = rd_valid && (rd_tag == req_tag);
  assign accept      = REQ_VALID && REQ_READY;
  assign unused_addr = ^REQ_ADDR[1:0];

  d_cache_array #(.LINES(LINES), .TAG_W(TAG_W)) u_array (
    .clk         (CLK),
    .rst         (RST),
    .idx         (req_idx),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .rd_tag      (rd_tag),
    .rd_line     (rd_line),
    .line_we     (line_we),
    .line_tag    (req_tag),
    .line_dat    (MEM_DI),
    .word_we     (word_we),
    .word_sel_in (req_word),
    .word_dat    (req_wdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:      if (REQ_VALID) state_n = ST_COMPARE;
      ST_COMPARE:   if (hit)                      state_n = ST_IDLE;
                    else if (rd_valid && rd_dirty) state_n = ST_WRITEBACK;
                    else                           state_n = ST_REFILL;
      ST_WRITEBACK: if (cnt == WB_LAST) state_n = ST_REFILL;
      ST_REFILL:    if (cnt == RF_LAST) state_n = ST_RESPOND;
      ST_RESPOND:   state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    REQ_READY  = (state == ST_IDLE) && !RST;
    RESP_VALID = ((state == ST_COMPARE) && hit) || (state == ST_RESPOND);
    // Load data is shown live in the response cycle and held in rdata_q afterwards.
    RESP_RDATA = (RESP_VALID && req_wen) ? word_sel(rd_line, req_word) : rdata_q;
    mem_go     = ((state == ST_WRITEBACK) || (state == ST_REFILL)) && (cnt == '0);
    MEM_CSN    = !mem_go;
    MEM_WEN    = !(mem_go && (state == ST_WRITEBACK));
    MEM_ADDR   = '0;
    MEM_DOUT   = '0;
    if (mem_go && (state == ST_WRITEBACK)) begin
      MEM_ADDR = {rd_tag, req_idx};
      MEM_DOUT = rd_line;
    end else if (mem_go) begin
      MEM_ADDR = req_line;
    end
    line_we = (state == ST_REFILL) && (cnt == RF_LAST);
    word_we = !req_wen && RESP_VALID;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_line  <= '0;
      req_word  <= '0;
      req_wen   <= 1'b1;
      req_wdata <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        req_line  <= REQ_ADDR[13:4];
        req_word  <= REQ_ADDR[3:2];
        req_wen   <= REQ_WEN;
        req_wdata <= REQ_WDATA;
      end
      if (state_n != state)
        cnt <= '0;
      else if ((state == ST_WRITEBACK) || (state == ST_REFILL))
        cnt <= cnt + CNT_W'(1);
      if (RESP_VALID && req_wen)
        rdata_q <= RESP_RDATA;
    end
  end

`ifdef D_CACHE_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      HIT_CNT  <= '0;
      MISS_CNT <= '0;
    end else if (state == ST_COMPARE) begin
      if (hit && (HIT_CNT != '1))
        HIT_CNT <= HIT_CNT + 32'd1;
      else if (!hit && (MISS_CNT != '1))
        MISS_CNT <= MISS_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_d_cache.sv
// tb_d_cache: randomized + directed bench for d_cache with a line-level cache/memory
// reference model; expected responses and memory accesses are queued at issue time
// and popped by independent monitors.
module tb_d_cache;

  localparam int LINES = 8;
  localparam int LAT   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid, req_ready, req_wen;
  logic [13:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         mem_csn, mem_wen;
  logic [9:0]   mem_addr;
  logic [127:0] mem_dout, mem_di;
`ifdef D_CACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  d_cache #(.LINES(LINES), .MEM_LATENCY(LAT)) dut (
    .CLK        (clk),
    .RST        (rst),
    .REQ_VALID  (req_valid),
    .REQ_READY  (req_ready),
    .REQ_WEN    (req_wen),
    .REQ_ADDR   (req_addr),
    .REQ_WDATA  (req_wdata),
    .RESP_VALID (resp_valid),
    .RESP_RDATA (resp_rdata),
    .MEM_CSN    (mem_csn),
    .MEM_WEN    (mem_wen),
    .MEM_ADDR   (mem_addr),
    .MEM_DOUT   (mem_dout),
    .MEM_DI     (mem_di)
`ifdef D_CACHE_STATS_EN
    ,
    .HIT_CNT    (hit_cnt),
    .MISS_CNT   (miss_cnt)
`endif
  );

  typedef struct {bit load; logic [31:0] rdata; int acc; int lat;} resp_t;
  typedef struct {bit wen; logic [9:0] addr; logic [127:0] dout;} macc_t;

  resp_t exp_resp[$];
  macc_t exp_mem[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int resp_done = 0;
  int rd_pulses = 0;

  // Reference model: backing memory plus cache contents, by plain line arithmetic.
  logic [127:0] mmem [1024];
  logic [127:0] cdata [LINES];
  bit           cvalid [LINES];
  bit           cdirty [LINES];
  int           ctag [LINES];
  logic [31:0]  last_rdata;
  int           m_hits, m_misses;

  // Memory the DUT actually talks to.
  logic [127:0] bmem [1024];
  bit           rd_pend;
  int           rd_cnt;
  logic [9:0]   rd_addr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      cvalid[i] = 0;
      cdirty[i] = 0;
      ctag[i]   = 0;
    end
    last_rdata = '0;
    m_hits     = 0;
    m_misses   = 0;
  endtask

  task automatic model_access(input logic [13:0] a, input bit wen, input logic [31:0] wd,
                              input int acc);
    int line, idx, tag, w;
    resp_t r;
    macc_t m;
    line = int'(a[13:4]);
    idx  = line % LINES;
    tag  = line / LINES;
    w    = int'(a[3:2]);
    r.load = wen;
    r.acc  = acc;
    if (cvalid[idx] && ctag[idx] == tag) begin
      r.lat = 1;
      m_hits++;
    end else begin
      m_misses++;
      if (cvalid[idx] && cdirty[idx]) begin
        m.wen  = 0;
        m.addr = 10'(ctag[idx] * LINES + idx);
        m.dout = cdata[idx];
        exp_mem.push_back(m);
        mmem[ctag[idx] * LINES + idx] = cdata[idx];
        r.lat = 3 + 2 * LAT;
      end else begin
        r.lat = 3 + LAT;
      end
      m.wen  = 1;
      m.addr = a[13:4];
      m.dout = '0;
      exp_mem.push_back(m);
      cdata[idx]  = mmem[line];
      cvalid[idx] = 1;
      cdirty[idx] = 0;
      ctag[idx]   = tag;
    end
    if (wen) begin
      last_rdata = cdata[idx][w*32 +: 32];
    end else begin
      cdata[idx][w*32 +: 32] = wd;
      cdirty[idx] = 1;
    end
    r.rdata = last_rdata;
    exp_resp.push_back(r);
  endtask

  // Response monitor.
  resp_t mon_r;
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (exp_resp.size() == 0) begin
        fail_now("unexpected_resp");
      end else begin
        mon_r = exp_resp.pop_front();
        check("resp_latency", 128'(cyc - mon_r.acc), 128'(mon_r.lat));
        check(mon_r.load ? "load_rdata" : "store_rdata_hold", resp_rdata, mon_r.rdata);
      end
      resp_done++;
    end
  end

  // Memory monitor and line-memory model; MEM_DI carries junk except in the capture cycle.
  macc_t mon_m;
  always @(negedge clk) begin
    if (rst) begin
      rd_pend = 0;
      mem_di  = {4{$urandom}};
    end else begin
      if (rd_pend) rd_cnt++;
      if (!mem_csn) begin
        if (exp_mem.size() == 0) begin
          fail_now("unexpected_mem_access");
        end else begin
          mon_m = exp_mem.pop_front();
          check("mem_wen", 128'(mem_wen), 128'(mon_m.wen));
          check("mem_addr", 128'(mem_addr), 128'(mon_m.addr));
          if (!mon_m.wen) check("wb_dout", mem_dout, mon_m.dout);
        end
        if (!mem_wen) begin
          bmem[mem_addr] = mem_dout;
        end else begin
          rd_pend = 1;
          rd_cnt  = 0;
          rd_addr = mem_addr;
          rd_pulses++;
        end
      end
      if (rd_pend && rd_cnt == LAT) begin
        mem_di  = bmem[rd_addr];
        rd_pend = 0;
      end else begin
        mem_di = {4{$urandom}};
      end
    end
  end

  task automatic do_req(input logic [13:0] a, input bit wen, input logic [31:0] wd,
                        input bit wait_resp);
    int n, target;
    @(negedge clk);
    req_valid = 1;
    req_addr  = a;
    req_wen   = wen;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail_now("req_ready_timeout");
      req_valid = 0;
      return;
    end
    model_access(a, wen, wd, cyc);
    target = resp_done + 1;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after acceptance: the latched copy must be used.
    req_valid = 0;
    req_addr  = 14'($urandom);
    req_wen   = 1'($urandom);
    req_wdata = $urandom;
    check("ready_low_busy", 128'(req_ready), 128'(0));
    if (wait_resp) begin
      n = 0;
      while (resp_done < target && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (resp_done < target) fail_now("resp_timeout");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  128'(req_ready),  128'(0));
    check({tag, "_resp_valid"}, 128'(resp_valid), 128'(0));
    check({tag, "_resp_rdata"}, 128'(resp_rdata), 128'(0));
    check({tag, "_mem_csn"},    128'(mem_csn),    128'(1));
    check({tag, "_mem_wen"},    128'(mem_wen),    128'(1));
    check({tag, "_mem_addr"},   128'(mem_addr),   128'(0));
    check({tag, "_mem_dout"},   mem_dout,         128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int n, base;
    logic [9:0]  line;
    logic [13:0] a;
    req_valid = 0;
    req_wen   = 1;
    req_addr  = '0;
    req_wdata = '0;
    mem_di    = '0;
    for (int i = 0; i < 1024; i++) begin
      bmem[i] = {$urandom, $urandom, $urandom, $urandom};
      mmem[i] = bmem[i];
    end
    bmem[1][31:0] = 32'hDEADBEEF;
    mmem[1][31:0] = 32'hDEADBEEF;
    model_reset();

    #1 rst = 1;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst = 0;

    // Cold load, hits, store hit, dirty conflict eviction.
    do_req(14'h0010, 1, 32'h0, 1);
    do_req(14'h0010, 1, 32'h0, 1);
    do_req(14'h0014, 1, 32'h0, 1);
    do_req(14'h0010, 0, 32'h12345678, 1);
    do_req(14'h0090, 1, 32'h0, 1);
`ifdef D_CACHE_STATS_EN
    check("hit_cnt_seq", hit_cnt, 128'(3));
    check("miss_cnt_seq", miss_cnt, 128'(2));
`endif

    // Store-miss allocate, then load back.
    do_req(14'h0024, 0, 32'hCAFEF00D, 1);
    do_req(14'h0024, 1, 32'h0, 1);

    // Reset two cycles after the refill request pulse.
    base = rd_pulses;
    do_req(14'h0010, 1, 32'h0, 0);
    n = 0;
    while (rd_pulses == base && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rd_pulses == base) fail_now("refill_pulse_timeout");
    repeat (2) @(negedge clk);
    rst = 1;
    #1 check_reset_outputs("mid_refill");
    void'(exp_resp.pop_back());
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    do_req(14'h0010, 1, 32'h0, 1);

    // Random traffic over 32 lines (4 tags per index) plus occasional far addresses.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) line = 10'($urandom);
      else                           line = 10'($urandom_range(0, 31));
      a = {line, 4'($urandom)};
      do_req(a, 1'($urandom), $urandom, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("exp_resp_drained", 128'(exp_resp.size()), 128'(0));
    check("exp_mem_drained", 128'(exp_mem.size()), 128'(0));
`ifdef D_CACHE_STATS_EN
    check("hit_cnt_final", hit_cnt, 128'(m_hits));
    check("miss_cnt_final", miss_cnt, 128'(m_misses));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/d_cache.md
Name: d_cache

Overview:
Direct-mapped, write-back, write-allocate data cache between the core's 32-bit load/store port and the 128-bit line-wide data memory, SP_DRAM (10-bit line address).
- Gives the core a single-outstanding request/response word interface.
- Turns misses into line refills and dirty-victim writebacks on the memory side.
- Memory side uses the memory's existing active-low CSN/WEN protocol.

Parameters:
LINES, 8, number of cache lines; power of two, 2..256; IDX_W = log2(LINES), TAG_W = 10 - IDX_W.
MEM_LATENCY, 4, cycles from MEM_CSN low until read data on MEM_DI is valid or a write is complete; >= 1.

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous, active-high reset
REQ_VALID  input  1  core request present
REQ_READY  output  1  cache accepts request; high only in IDLE
REQ_WEN  input  1  active-low write enable (0 = store, 1 = load)
REQ_ADDR  input  14  byte address; [13:4] line address, [3:2] word select, [1:0] ignored
REQ_WDATA  input  32  store data
RESP_VALID  output  1  one-cycle pulse: request complete
RESP_RDATA  output  32  load data, valid with RESP_VALID on loads
MEM_CSN  output  1  active-low memory chip select, one-cycle pulse per access
MEM_WEN  output  1  active-low memory write enable, meaningful while MEM_CSN = 0
MEM_ADDR  output  10  line address
MEM_DOUT  output  128  writeback line to memory
MEM_DI  input  128  refill line from memory

Behaviour:
- Reset (RST = 1, asynchronous): all valid and dirty bits cleared, state IDLE.
  - Outputs: RESP_VALID = 0, RESP_RDATA = 0, MEM_CSN = 1, MEM_WEN = 1, MEM_ADDR = 0, MEM_DOUT = 0.
  - REQ_READY is 0 while RST is high.
  - Reset mid-refill or mid-writeback abandons the memory access. The lost dirty data is accepted.
- Handshake:
  - A request is accepted on an edge where REQ_VALID and REQ_READY are both 1.
  - Address, WEN and WDATA are latched at acceptance. Later input changes are ignored.
  - Exactly one RESP_VALID pulse per accepted request. No new acceptance until after that pulse.
- Address split: index = REQ_ADDR[4+IDX_W-1:4], tag = REQ_ADDR[13:4+IDX_W], word = REQ_ADDR[3:2]. Word 0 is line bits [31:0].
- States:
  - IDLE: REQ_READY = 1. On acceptance go to COMPARE (cycle T+1 for acceptance edge T).
  - COMPARE: hit = valid and tag match.
    - Hit: RESP_VALID = 1 in this cycle. Load returns the word. Store merges the word and sets dirty. Next state IDLE.
    - Miss with clean or invalid victim: go to REFILL.
    - Miss with valid and dirty victim: go to WRITEBACK.
  - WRITEBACK:
    - First cycle drives MEM_CSN = 0, MEM_WEN = 0, MEM_ADDR = {victim tag, index}, MEM_DOUT = victim line.
    - Waits MEM_LATENCY cycles total, then goes to REFILL.
  - REFILL:
    - First cycle drives MEM_CSN = 0, MEM_WEN = 1, MEM_ADDR = request line address.
    - MEM_DI is captured MEM_LATENCY cycles later. The line is written with valid = 1, new tag, dirty = 0.
    - Next state RESPOND.
  - RESPOND:
    - Load: RESP_RDATA = selected word from the filled line.
    - Store: the word is merged into the line and dirty is set.
    - RESP_VALID = 1. Next state IDLE.
- Latency from acceptance edge T: hit response at T+1; clean miss at T+3+MEM_LATENCY; dirty miss at T+3+2*MEM_LATENCY.
- MEM_CSN is low for exactly one cycle per memory access. No access is issued outside WRITEBACK or REFILL.
- RESP_RDATA holds its last value when RESP_VALID = 0. It is unchanged on store responses.
- A wait counter of width clog2(MEM_LATENCY+1) counts latency. It resets to 0 on every state entry.

Optional Feature:
- Macro: D_CACHE_STATS_EN.
- When defined, adds two 32-bit outputs, HIT_CNT and MISS_CNT.
  - Reset to 0.
  - Incremented in COMPARE on hit or miss respectively.
  - Saturate at 0xFFFFFFFF.
- When undefined, the ports and counters are absent. No other behaviour changes.

Decomposition:
- Package d_cache_pkg:
  - state encoding (IDLE, COMPARE, WRITEBACK, REFILL, RESPOND);
  - LINE_W = 128, WORD_W = 32, MEM_AW = 10;
  - word-select and line-merge helper functions.
- Sub-module d_cache_array holds the tag, valid, dirty and data arrays.
  - Asynchronous read by index.
  - Synchronous write port (line write, word merge, dirty set).
  - Valid clear on RST.
- The d_cache top holds the FSM, request latch and wait counter.

Test Plan:
1. Cold load: REQ_ADDR = 0x0010 after reset, LINES = 8, MEM_LATENCY = 4, MEM_DI = line with word0 = 0xDEADBEEF.
   - MEM_CSN low once at T+2 with MEM_ADDR = 0x001, MEM_WEN = 1.
   - RESP_VALID at T+7, RESP_RDATA = 0xDEADBEEF.
2. Load hit: repeat load of 0x0010, then load 0x0014. Each gives RESP_VALID at T+1 and no MEM_CSN activity. The 0x0014 load returns word1 of the filled line.
3. Store hit then conflict eviction:
   - Store 0x12345678 to 0x0010: response T+1.
   - Load 0x0090 (same index 1, tag 1): WRITEBACK with MEM_ADDR = 0x001 and MEM_DOUT[31:0] = 0x12345678, then REFILL with MEM_ADDR = 0x009. RESP_VALID at T+11.
4. Store miss allocate: store 0xCAFEF00D to 0x0024 on a cold line.
   - Refill of line 0x002, RESP_VALID at T+7.
   - Subsequent load of 0x0024 hits and returns 0xCAFEF00D.
5. Reset mid-refill: assert RST two cycles after the REFILL MEM_CSN pulse.
   - All outputs go to reset values immediately.
   - After release, load 0x0010 misses (valid cleared).
6. With D_CACHE_STATS_EN: the sequence of scenarios 1–3 yields HIT_CNT = 3, MISS_CNT = 2.
